// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types for the APB requester: FSM state encoding,
//                default bus widths and the response record.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    // Completion record; rdata is sized to the package default data width
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_if
//  Description : APB bus bundle with requester/completer modports and
//                protocol assertions (enable implies select, SETUP is followed
//                by ACCESS, address/data stable in ACCESS, no X on controls).
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) (
    input logic Pclk,
    input logic Prst
);

    logic [ADDR_W-1:0] Paddr;
    logic              Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [DATA_W-1:0] Pwdata;
    logic              Pready;
    logic              Pslverr;
    logic [DATA_W-1:0] Prdata;

    modport master (
        output Paddr, Pselx, Penable, Pwrite, Pwdata,
        input  Pready, Pslverr, Prdata
    );

    modport slave (
        input  Paddr, Pselx, Penable, Pwrite, Pwdata,
        output Pready, Pslverr, Prdata
    );

    a_enable_needs_select: assert property (@(posedge Pclk) disable iff (Prst)
        Penable |-> Pselx);

    a_setup_then_access: assert property (@(posedge Pclk) disable iff (Prst)
        (Pselx && !Penable) |=> (Pselx && Penable));

    a_setup_stable: assert property (@(posedge Pclk) disable iff (Prst)
        (Pselx && !Penable) |=> ($stable(Paddr) && $stable(Pwdata) && $stable(Pwrite)));

    // A wait state either continues the same transfer or the transfer was aborted
    a_wait_stable: assert property (@(posedge Pclk) disable iff (Prst)
        (Penable && !Pready) |=> (!Pselx || ($stable(Paddr) && $stable(Pwdata) && $stable(Pwrite))));

    a_ctrl_known: assert property (@(posedge Pclk) disable iff (Prst)
        !$isunknown({Pselx, Penable, Pwrite}));

endinterface
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_wait_timer
//  Description : Counts ACCESS wait cycles; expired_o flags the last allowed
//                wait cycle (count == TIMEOUT-1). TIMEOUT = 0 removes the
//                counter and never expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    generate
        if (TIMEOUT != 0) begin : g_timer
            localparam int unsigned      CNT_W  = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            // Clear outside ACCESS, count each wait cycle inside it
            always_comb begin
                count_d = count_q;
                if (clear_i) begin
                    count_d = '0;
                end else if (inc_i) begin
                    count_d = count_q + 1'b1;
                end
            end

            // Counter register
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired_o = (count_q == C_LAST);
        end else begin : g_off
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : APB requester. Converts a valid/ready command stream into
//                APB SETUP/ACCESS transfers and returns one response pulse per
//                command, with PREADY wait states, PSLVERR and a wait timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              Pclk,
    input  logic              Prst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    apb_if.master             apb
);

    apb_state_e        state_q;
    apb_state_e        state_d;
    logic [ADDR_W-1:0] paddr_q;
    logic [ADDR_W-1:0] paddr_d;
    logic              pwrite_q;
    logic              pwrite_d;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_q;
    logic              rsp_valid_d;
    apb_rsp_t          rsp_q;
    apb_rsp_t          rsp_d;

    logic              w_cmd_ready;
    logic              w_expired;
    logic              w_timer_clear;
    logic              w_timer_inc;

    assign w_timer_clear = (state_q != APB_ACCESS);
    assign w_timer_inc   = (state_q == APB_ACCESS) && !apb.Pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (Pclk),
        .rst_i     (Prst),
        .clear_i   (w_timer_clear),
        .inc_i     (w_timer_inc),
        .expired_o (w_expired)
    );

    // Next state, command handshake and completion record
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_d       = '0;
        w_cmd_ready = 1'b0;

        case (state_q)
            APB_IDLE: begin
                w_cmd_ready = 1'b1;
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (apb.Pready) begin
                    // Completion frees the bus, so a new command may start now
                    w_cmd_ready   = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = pwrite_q ? {APB_DATA_W{1'b0}} : APB_DATA_W'(apb.Prdata);
                    rsp_d.err     = apb.Pslverr;
                    state_d       = APB_IDLE;
                end else if (w_expired) begin
                    rsp_valid_d   = 1'b1;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = APB_IDLE;
                end
            end
            default: begin
                state_d = APB_IDLE;
            end
        endcase

        if (cmd_valid_i && w_cmd_ready) begin
            state_d  = APB_SETUP;
            paddr_d  = cmd_addr_i;
            pwrite_d = cmd_write_i;
            pwdata_d = cmd_wdata_i;
        end
    end

    // FSM state and bus address/data registers
    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            state_q  <= APB_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end

    // Response registers; fields are zero whenever no pulse is issued
    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    // Select/enable decode straight from the state register: glitch-free
    // and forced low the instant reset is applied
    assign apb.Pselx   = (state_q != APB_IDLE);
    assign apb.Penable = (state_q == APB_ACCESS);
    assign apb.Paddr   = paddr_q;
    assign apb.Pwrite  = pwrite_q;
    assign apb.Pwdata  = pwdata_q;

    assign cmd_ready_o   = w_cmd_ready;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = DATA_W'(rsp_q.rdata);
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_bridge
//  Description : Self-checking bench for apb_master_bridge (TIMEOUT = 4) with
//                a scripted APB completer and a transfer-level expectation
//                model (latency and response derived per command).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int unsigned TMO = 4;

    logic        Pclk;
    logic        Prst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int errors = 0;
    int checks = 0;

    apb_if #(.ADDR_W(32), .DATA_W(32)) bus (.Pclk(Pclk), .Prst(Prst));

    apb_master_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .Pclk          (Pclk),
        .Prst          (Prst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .apb           (bus)
    );

    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;

    // ---------------- scripted completer ----------------
    // Each transfer takes the next plan entry when its SETUP phase is seen:
    // wt = number of Pready=0 cycles before Pready=1, er = Pslverr at completion.
    typedef struct packed {
        logic [31:0] wt;
        logic        er;
        logic [31:0] rd;
    } plan_t;

    plan_t       plan_q[$];
    plan_t       cur;
    logic [31:0] acc_cnt;

    initial cur = '0;

    always @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            acc_cnt <= 32'd0;
        end else if (bus.Pselx && !bus.Penable) begin
            if (plan_q.size() != 0) cur <= plan_q.pop_front();
            else                    cur <= '0;
            acc_cnt <= 32'd0;
        end else if (bus.Penable) begin
            acc_cnt <= acc_cnt + 32'd1;
        end
    end

    // Outside ACCESS the completer shows ready/error/junk data, which must be ignored
    assign bus.Pready  = !bus.Penable || (acc_cnt >= cur.wt);
    assign bus.Pslverr = bus.Pready ? (!bus.Penable || cur.er) : 1'b1;
    assign bus.Prdata  = bus.Penable ? cur.rd : 32'hBAD0_BAD0;

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated command. Expected cycle-by-cycle behaviour comes from the
    // transfer model: response appears 3 + min(wt, TMO-1) cycles after accept;
    // the transfer times out when the completer would wait TMO or more cycles.
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int wt, input logic er, input logic [31:0] rd);
        logic        to;
        int          lat;
        logic        exp_sel;
        logic        exp_en;
        logic        exp_rdy;
        plan_t       p;
        to  = (wt >= int'(TMO));
        lat = 3 + (to ? int'(TMO) - 1 : wt);
        p.wt = 32'(wt);
        p.er = er;
        p.rd = rd;
        plan_q.push_back(p);

        @(negedge Pclk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        check("ready_idle", {63'd0, cmd_ready}, 64'd1);
        @(posedge Pclk);
        #1;
        cmd_valid = 1'b0;

        for (int k = 1; k <= lat; k++) begin
            @(negedge Pclk);
            exp_sel = (k < lat);
            exp_en  = (k >= 2) && (k < lat);
            exp_rdy = (k == 1) ? 1'b0 : ((k < lat) ? ((k == lat - 1) && !to) : 1'b1);
            check($sformatf("psel_c%0d", k),  {63'd0, bus.Pselx},   {63'd0, exp_sel});
            check($sformatf("pen_c%0d", k),   {63'd0, bus.Penable}, {63'd0, exp_en});
            check($sformatf("ready_c%0d", k), {63'd0, cmd_ready},   {63'd0, exp_rdy});
            if (exp_sel) begin
                check($sformatf("paddr_c%0d", k),  {32'd0, bus.Paddr},  {32'd0, a});
                check($sformatf("pwrite_c%0d", k), {63'd0, bus.Pwrite}, {63'd0, w});
                check($sformatf("pwdata_c%0d", k), {32'd0, bus.Pwdata}, {32'd0, d});
            end
            if (k == lat) begin
                check("rsp_valid", {63'd0, rsp_valid},   64'd1);
                check("rsp_rdata", {32'd0, rsp_rdata},   {32'd0, (to || w) ? 32'd0 : rd});
                check("rsp_err",   {63'd0, rsp_err},     {63'd0, to | er});
                check("rsp_tmo",   {63'd0, rsp_timeout}, {63'd0, to});
            end else begin
                check($sformatf("rsp_idle_c%0d", k),
                      {32'd0, rsp_rdata[31:2], rsp_valid, rsp_err | rsp_timeout | (|rsp_rdata[1:0])},
                      64'd0);
            end
        end
    endtask

    // ---------------- back-to-back table (cycle k -> bit k-1) ----------------
    logic [6:0]  t5_sel  = 7'b011_1111;
    logic [6:0]  t5_en   = 7'b010_1010;
    logic [6:0]  t5_rsp  = 7'b101_0100;
    logic [6:0]  t5_rdy  = 7'b110_1010;
    logic [31:0] t5_addr [3];
    logic [31:0] t5_rd   [3];

    // ---------------- directed + random sequence ----------------
    initial begin
        plan_t p;
        Prst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'd0;
        cmd_wdata = 32'd0;

        // Reset state
        repeat (2) @(posedge Pclk);
        @(negedge Pclk);
        check("rst_psel",  {63'd0, bus.Pselx},   64'd0);
        check("rst_pen",   {63'd0, bus.Penable}, 64'd0);
        check("rst_pwr",   {63'd0, bus.Pwrite},  64'd0);
        check("rst_paddr", {32'd0, bus.Paddr},   64'd0);
        check("rst_pwd",   {32'd0, bus.Pwdata},  64'd0);
        check("rst_rsp",   {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'd0);
        check("rst_rdata", {32'd0, rsp_rdata},   64'd0);
        check("rst_ready", {63'd0, cmd_ready},   64'd1);
        Prst = 1'b0;

        // 1: zero-wait write
        do_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_5555);
        // 2: read with three wait states
        do_cmd(1'b0, 32'h24, 32'h0, 3, 1'b0, 32'h1234_5678);
        // 3: write with slave error
        do_cmd(1'b1, 32'h30, 32'hCAFE_F00D, 1, 1'b1, 32'h0);
        // 4: completer never ready -> timeout
        do_cmd(1'b0, 32'h40, 32'h0, 1000, 1'b0, 32'h1111_1111);

        // 5: three back-to-back reads with cmd_valid held
        for (int i = 0; i < 3; i++) begin
            t5_addr[i] = 32'h100 + 32'(4 * i);
            t5_rd[i]   = $urandom;
            p.wt = 32'd0;
            p.er = 1'b0;
            p.rd = t5_rd[i];
            plan_q.push_back(p);
        end
        @(negedge Pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = t5_addr[0];
        for (int k = 1; k <= 7; k++) begin
            @(negedge Pclk);
            check($sformatf("b2b_psel_c%0d", k), {63'd0, bus.Pselx},   {63'd0, t5_sel[k-1]});
            check($sformatf("b2b_pen_c%0d", k),  {63'd0, bus.Penable}, {63'd0, t5_en[k-1]});
            check($sformatf("b2b_rsp_c%0d", k),  {63'd0, rsp_valid},   {63'd0, t5_rsp[k-1]});
            check($sformatf("b2b_rdy_c%0d", k),  {63'd0, cmd_ready},   {63'd0, t5_rdy[k-1]});
            if (k <= 6)
                check($sformatf("b2b_paddr_c%0d", k), {32'd0, bus.Paddr}, {32'd0, t5_addr[(k-1)/2]});
            if (t5_rsp[k-1])
                check($sformatf("b2b_rdata_c%0d", k), {32'd0, rsp_rdata}, {32'd0, t5_rd[(k-3)/2]});
            if (k == 1) cmd_addr  = t5_addr[1];
            if (k == 3) cmd_addr  = t5_addr[2];
            if (k == 5) cmd_valid = 1'b0;
        end

        // 6: reset during ACCESS
        p.wt = 32'd2;
        p.er = 1'b0;
        p.rd = 32'h7777_7777;
        plan_q.push_back(p);
        @(negedge Pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h200;
        cmd_wdata = 32'hA5A5_A5A5;
        @(posedge Pclk);
        #1;
        cmd_valid = 1'b0;
        @(negedge Pclk);
        @(negedge Pclk);
        check("mid_pen", {63'd0, bus.Penable}, 64'd1);
        #2;
        Prst = 1'b1;
        #1;
        check("arst_sel",   {62'd0, bus.Pselx, bus.Penable}, 64'd0);
        check("arst_addr",  {32'd0, bus.Paddr},  64'd0);
        check("arst_wdata", {32'd0, bus.Pwdata}, 64'd0);
        check("arst_pwr",   {63'd0, bus.Pwrite}, 64'd0);
        @(negedge Pclk);
        Prst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Pclk);
            check($sformatf("arst_norsp_%0d", k), {62'd0, rsp_valid, bus.Pselx}, 64'd0);
        end
        do_cmd(1'b0, 32'h204, 32'h0, 0, 1'b0, 32'h0BAD_CAFE);

        // Random commands against the transfer model
        for (int n = 0; n < 40; n++) begin
            do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom,
                   int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence stalls
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
